// File: rtl/md_seq_ctrl.sv
// EX-stage sequencer for the multi-cycle M-extension units.
// Stalls the pipe, drives the divider handshake and latches the result.
module md_seq_ctrl #(
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [3:0]  alu_op_i,
  input  logic        flush_i,
  input  logic [31:0] mul_result_i,
  input  logic        div_done_i,
  input  logic [31:0] div_result_i,
  output logic        div_start_o,
  output logic        div_abort_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    MWAIT,
    DSTART,
    DWAIT,
    DONE
  } state_t;

  localparam logic MUL_EN = (MUL_LAT > 0);
  localparam logic [CNT_W-1:0] MUL_INIT =
    MUL_EN ? CNT_W'(MUL_LAT - 1) : '0;
  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(DIV_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic             tmo_q, tmo_d;

  logic is_mul, is_div, md_req;

  assign is_mul = MUL_EN && (alu_op_i == 4'b1010);
  assign is_div = (alu_op_i[3:2] == 2'b11);
  assign md_req = ex_valid_i & ~flush_i & (is_mul | is_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    res_d          = res_q;
    tmo_d          = tmo_q;
    stall_o        = 1'b0;
    div_start_o    = 1'b0;
    div_abort_o    = 1'b0;
    result_valid_o = 1'b0;
    busy_o         = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        stall_o = md_req;
        if (md_req) begin
          if (is_mul) begin
            state_d = MWAIT;
            cnt_d   = MUL_INIT;
          end else begin
            state_d = DSTART;
          end
        end
      end
      MWAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            res_d   = mul_result_i;
            state_d = DONE;
          end
        end
      end
      DSTART: begin
        // Abort wins over start so the divider never sees both
        if (flush_i) begin
          div_abort_o = 1'b1;
          state_d     = IDLE;
        end else begin
          stall_o     = 1'b1;
          div_start_o = 1'b1;
          cnt_d       = '0;
          state_d     = DWAIT;
        end
      end
      DWAIT: begin
        if (flush_i) begin
          div_abort_o = 1'b1;
          state_d     = IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (div_done_i) begin
            res_d   = div_result_i;
            state_d = DONE;
          end else if (cnt_q == DIV_LAST) begin
            res_d   = 32'hFFFF_FFFF;
            tmo_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        result_valid_o = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result_o  = res_q;
  assign timeout_o = tmo_q;

endmodule
